// File: rtl/alu_acu.sv
// Execute stage of the 8-bit processor: ALU, accumulator and registered
// Carry/Zero/Sign/Overflow/Parity flags. One-cycle latency and purely
// registered outputs. Reserved opcodes leave all state untouched.
module alu_acu #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            aluOper,
    input  logic                  ceAcu,
    input  logic [data_width-1:0] operandB,
    output logic [data_width-1:0] acu,
    output logic                  flag_c_out,
    output logic                  flag_z_out,
    output logic                  flag_s_out,
    output logic                  flag_v_out,
    output logic                  flag_p_out
);

    localparam int MSB = data_width - 1;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_ADDC = 4'b1000;
    localparam logic [3:0] OP_SUBC = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;

    logic [data_width:0]   sumExt;
    logic [MSB:0]          result;
    logic [MSB:0]          addend;
    logic [MSB:0]          one;
    logic [data_width:0]   carryInExt;
    logic                  carryNext;
    logic                  ovfNext;
    logic                  opValid;
    logic                  writeEn;

    assign one        = {{MSB{1'b0}}, 1'b1};
    assign carryInExt = {{data_width{1'b0}}, flag_c_out};

    // Result, carry/borrow and overflow for the selected operation.
    // For subtracts the (data_width+1)-bit difference wraps negative, so its
    // top bit is exactly the unsigned borrow.
    always_comb begin
        sumExt    = '0;
        result    = '0;
        addend    = '0;
        carryNext = flag_c_out;
        ovfNext   = flag_v_out;
        opValid   = 1'b1;
        case (aluOper)
            OP_LOAD: begin
                result = operandB;
            end
            OP_INC, OP_ADD, OP_ADDC: begin
                if (aluOper == OP_INC) begin
                    addend = one;
                    sumExt = {1'b0, acu} + {1'b0, one};
                end else if (aluOper == OP_ADD) begin
                    addend = operandB;
                    sumExt = {1'b0, acu} + {1'b0, operandB};
                end else begin
                    addend = operandB + {{MSB{1'b0}}, flag_c_out};
                    sumExt = {1'b0, acu} + {1'b0, operandB} + carryInExt;
                end
                result    = sumExt[MSB:0];
                carryNext = sumExt[data_width];
                ovfNext   = (acu[MSB] == addend[MSB]) && (result[MSB] != acu[MSB]);
            end
            OP_SUB, OP_SUBC, OP_DEC: begin
                if (aluOper == OP_DEC) begin
                    addend = one;
                    sumExt = {1'b0, acu} - {1'b0, one};
                end else if (aluOper == OP_SUB) begin
                    addend = operandB;
                    sumExt = {1'b0, acu} - {1'b0, operandB};
                end else begin
                    addend = operandB;
                    sumExt = {1'b0, acu} - {1'b0, operandB} - carryInExt;
                end
                result    = sumExt[MSB:0];
                carryNext = sumExt[data_width];
                ovfNext   = (acu[MSB] != addend[MSB]) && (result[MSB] != acu[MSB]);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                if (aluOper == OP_AND) begin
                    result = acu & operandB;
                end else if (aluOper == OP_OR) begin
                    result = acu | operandB;
                end else if (aluOper == OP_XOR) begin
                    result = acu ^ operandB;
                end else begin
                    result = ~acu;
                end
                carryNext = 1'b0;
                ovfNext   = 1'b0;
            end
            default: begin
                opValid = 1'b0;
            end
        endcase
    end

    assign writeEn = ceAcu && opValid;

    // Accumulator and flag register; reset discards any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acu        <= '0;
            flag_c_out <= 1'b0;
            flag_z_out <= 1'b0;
            flag_s_out <= 1'b0;
            flag_v_out <= 1'b0;
            flag_p_out <= 1'b0;
        end else if (writeEn) begin
            acu        <= result;
            flag_c_out <= carryNext;
            flag_z_out <= (result == '0);
            flag_s_out <= result[MSB];
            flag_v_out <= ovfNext;
            flag_p_out <= ~^result;
        end
    end

endmodule
